// File: rtl/seq_datapath_core.sv
// seq_datapath_core: multi-cycle register-file datapath with A/G staging, Z/C flags and a valid/ready instruction port
module seq_datapath_core #(
  parameter int WIDTH = 16,
  parameter int NREGS = 8,
  localparam int RW = $clog2(NREGS)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             instr_valid,
  output logic             instr_ready,
  input  logic [3:0]       instr_op,
  input  logic [RW-1:0]    instr_rx,
  input  logic [RW-1:0]    instr_ry,
  input  logic [WIDTH-1:0] instr_imm,
  output logic             done,
  output logic             illegal,
  output logic             flag_z,
  output logic             flag_c,
  input  logic [RW-1:0]    dbg_sel,
  output logic [WIDTH-1:0] dbg_data
);
  typedef enum logic [2:0] {IDLE, T1, T2, T3, DONE} state_t;
  state_t state, nxt;
  logic [WIDTH-1:0] r [NREGS];
  logic [WIDTH-1:0] a, g, b, ir_imm;
  logic [3:0] ir_op;
  logic [RW-1:0] ir_rx, ir_ry;
  logic z, c;
  logic [WIDTH:0] alu;
  assign b = r[ir_ry];
  // bit WIDTH carries the ADD carry, SUB borrow or SHL shifted-out bit; zero for logic ops
  always_comb begin
    alu = ir_op == 4'd2 ? {1'b0, a} + {1'b0, b} :
          ir_op == 4'd3 ? {1'b0, a} - {1'b0, b} :
          ir_op == 4'd4 ? {1'b0, a ^ b} :
          ir_op == 4'd5 ? {1'b0, a & b} :
          ir_op == 4'd6 ? {1'b0, a | b} :
                          {a, 1'b0};
  end
  always_comb begin
    nxt = state == IDLE ? (instr_valid ? (instr_op[3] ? DONE : T1) : IDLE) :
          state == T1   ? (ir_op[3:1] == 3'd0 ? DONE : T2) :
          state == T2   ? T3 :
          state == T3   ? DONE : IDLE;
  end
  assign instr_ready = rst && state == IDLE;
  assign done = state == DONE;
  assign illegal = done && ir_op[3];
  assign flag_z = z;
  assign flag_c = c;
  assign dbg_data = r[dbg_sel];
  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= IDLE;
      for (int i = 0; i < NREGS; i++) r[i] <= '0;
      a <= '0;
      g <= '0;
      ir_op <= '0;
      ir_rx <= '0;
      ir_ry <= '0;
      ir_imm <= '0;
      z <= 1'b0;
      c <= 1'b0;
    end else begin
      state <= nxt;
      if (instr_ready && instr_valid) begin
        ir_op <= instr_op;
        ir_rx <= instr_rx;
        ir_ry <= instr_ry;
        ir_imm <= instr_imm;
      end
      if (state == T1) begin
        if (ir_op == 4'd0) r[ir_rx] <= ir_imm;
        else if (ir_op == 4'd1) r[ir_rx] <= b;
        else a <= r[ir_rx];
      end
      if (state == T2) begin
        g <= alu[WIDTH-1:0];
        z <= alu[WIDTH-1:0] == '0;
        c <= alu[WIDTH];
      end
      if (state == T3) r[ir_rx] <= g;
    end
  end
endmodule

// File: tb/tb_seq_datapath_core.sv
// tb_seq_datapath_core: directed table, reset-abort sequence and random instructions on 16x8 and 8x4 instances
module tb_seq_datapath_core;
  logic clk = 1'b0;
  logic rst, iv, sel;
  logic [3:0] op;
  logic [2:0] rx, ry, ds;
  logic [15:0] imm;
  logic rdy16, dn16, il16, z16, c16, rdy8, dn8, il8, z8, c8;
  logic [15:0] dd16;
  logic [7:0] dd8;
  logic rdy, dn, il, zf, cf;
  logic [15:0] dd;
  int checks = 0, errors = 0;
  int unsigned mr [2][8];
  bit mz [2], mc [2];

  always #5 clk = ~clk;

  seq_datapath_core #(.WIDTH(16), .NREGS(8)) u16 (
    .clk(clk), .rst(rst), .instr_valid(iv && !sel), .instr_ready(rdy16),
    .instr_op(op), .instr_rx(rx), .instr_ry(ry), .instr_imm(imm),
    .done(dn16), .illegal(il16), .flag_z(z16), .flag_c(c16),
    .dbg_sel(ds), .dbg_data(dd16)
  );
  seq_datapath_core #(.WIDTH(8), .NREGS(4)) u8 (
    .clk(clk), .rst(rst), .instr_valid(iv && sel), .instr_ready(rdy8),
    .instr_op(op), .instr_rx(rx[1:0]), .instr_ry(ry[1:0]), .instr_imm(imm[7:0]),
    .done(dn8), .illegal(il8), .flag_z(z8), .flag_c(c8),
    .dbg_sel(ds[1:0]), .dbg_data(dd8)
  );

  assign rdy = sel ? rdy8 : rdy16;
  assign dn = sel ? dn8 : dn16;
  assign il = sel ? il8 : il16;
  assign zf = sel ? z8 : z16;
  assign cf = sel ? c8 : c16;
  assign dd = sel ? {8'h00, dd8} : dd16;

  task automatic chk(input string nm, input int unsigned act, input int unsigned exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s (dut%0d): got %0h expected %0h", nm, sel ? 8 : 16, act, exp);
    end
  endtask

  task automatic clear_model();
    for (int s = 0; s < 2; s++) begin
      for (int i = 0; i < 8; i++) mr[s][i] = 0;
      mz[s] = 0;
      mc[s] = 0;
    end
  endtask

  task automatic check_regs();
    int nr = sel ? 4 : 8;
    for (int i = 0; i < nr; i++) begin
      ds = 3'(i);
      #1;
      chk($sformatf("R%0d", i), dd, mr[sel][i]);
    end
  endtask

  // Issue one instruction, measure latency, then compare against the arithmetic model
  task automatic exec(input logic [3:0] o, input logic [2:0] x, input logic [2:0] y,
                      input logic [15:0] im, input bit hold);
    int n, lat, w, explat;
    int unsigned msk, av, bv, res, cc;
    w = sel ? 8 : 16;
    msk = (32'd1 << w) - 1;
    @(negedge clk);
    op = o; rx = x; ry = y; imm = im; iv = 1'b1;
    n = 0;
    while (!rdy && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("ready wait", rdy, 1);
    @(negedge clk);
    iv = hold;
    lat = 1;
    while (!dn && lat < 10) begin
      chk("ready busy", rdy, 0);
      if (hold) begin
        op = 4'($urandom); rx = 3'($urandom); ry = 3'($urandom); imm = 16'($urandom);
      end
      @(negedge clk);
      lat++;
    end
    iv = 1'b0;
    explat = o[3] ? 1 : (o < 2 ? 2 : 4);
    chk("latency", lat, explat);
    chk("illegal", il, o[3]);
    av = mr[sel][x];
    bv = mr[sel][y];
    res = av;
    cc = 0;
    case (o)
      4'd0: res = im;
      4'd1: res = bv;
      4'd2: begin res = av + bv; cc = (res >> w) & 1; end
      4'd3: begin res = av - bv; cc = av < bv; end
      4'd4: res = av ^ bv;
      4'd5: res = av & bv;
      4'd6: res = av | bv;
      4'd7: begin res = av * 2; cc = (av >> (w - 1)) & 1; end
      default: ;
    endcase
    res &= msk;
    if (!o[3]) mr[sel][x] = res;
    if (o >= 2 && o <= 7) begin
      mz[sel] = res == 0;
      mc[sel] = cc[0];
    end
    chk("flag_z", zf, mz[sel]);
    chk("flag_c", cf, mc[sel]);
    check_regs();
  endtask

  typedef struct {
    bit s;
    logic [3:0] o;
    logic [2:0] x, y;
    logic [15:0] im, ex;
    bit ez, ec;
  } vec_t;
  vec_t tbl [22];

  initial begin
    tbl[0]  = '{0, 4'd0, 3, 0, 16'h1234, 16'h1234, 0, 0};
    tbl[1]  = '{0, 4'd0, 0, 0, 16'hFFFF, 16'hFFFF, 0, 0};
    tbl[2]  = '{0, 4'd0, 1, 0, 16'h0001, 16'h0001, 0, 0};
    tbl[3]  = '{0, 4'd2, 0, 1, 16'h0000, 16'h0000, 1, 1};
    tbl[4]  = '{0, 4'd0, 2, 0, 16'h0003, 16'h0003, 1, 1};
    tbl[5]  = '{0, 4'd0, 4, 0, 16'h0005, 16'h0005, 1, 1};
    tbl[6]  = '{0, 4'd3, 2, 4, 16'h0000, 16'hFFFE, 0, 1};
    tbl[7]  = '{0, 4'd1, 5, 2, 16'h0000, 16'hFFFE, 0, 1};
    tbl[8]  = '{0, 4'd0, 6, 0, 16'h8001, 16'h8001, 0, 1};
    tbl[9]  = '{0, 4'd2, 6, 6, 16'h0000, 16'h0002, 0, 1};
    tbl[10] = '{0, 4'd7, 6, 3, 16'h0000, 16'h0004, 0, 0};
    tbl[11] = '{0, 4'hF, 0, 0, 16'hABCD, 16'h0000, 0, 0};
    tbl[12] = '{1, 4'd0, 0, 0, 16'h00FF, 16'h00FF, 0, 0};
    tbl[13] = '{1, 4'd0, 1, 0, 16'h0001, 16'h0001, 0, 0};
    tbl[14] = '{1, 4'd2, 0, 1, 16'h0000, 16'h0000, 1, 1};
    tbl[15] = '{1, 4'd0, 2, 0, 16'h0003, 16'h0003, 1, 1};
    tbl[16] = '{1, 4'd0, 3, 0, 16'h0005, 16'h0005, 1, 1};
    tbl[17] = '{1, 4'd3, 2, 3, 16'h0000, 16'h00FE, 0, 1};
    tbl[18] = '{1, 4'd1, 1, 2, 16'h0000, 16'h00FE, 0, 1};
    tbl[19] = '{1, 4'd0, 3, 0, 16'h0081, 16'h0081, 0, 1};
    tbl[20] = '{1, 4'd2, 3, 3, 16'h0000, 16'h0002, 0, 1};
    tbl[21] = '{1, 4'd7, 3, 0, 16'h0000, 16'h0004, 0, 0};
    clear_model();
    rst = 1'b0; iv = 1'b0; sel = 1'b0; op = '0; rx = '0; ry = '0; imm = '0; ds = '0;
    repeat (3) begin
      @(negedge clk);
      chk("ready in reset 16", rdy16, 0);
      chk("ready in reset 8", rdy8, 0);
      chk("done in reset", dn16 | dn8, 0);
    end
    rst = 1'b1;
    for (int s = 0; s < 2; s++) begin
      sel = s[0];
      chk("reset z", zf, 0);
      chk("reset c", cf, 0);
      check_regs();
    end
    for (int i = 0; i < 22; i++) begin
      sel = tbl[i].s;
      exec(tbl[i].o, tbl[i].x, tbl[i].y, tbl[i].im, i % 3 == 0);
      ds = tbl[i].x;
      #1;
      chk($sformatf("tbl%0d value", i), dd, tbl[i].ex);
      chk($sformatf("tbl%0d z", i), zf, tbl[i].ez);
      chk($sformatf("tbl%0d c", i), cf, tbl[i].ec);
    end
    // Reset lands while an ADD is in T2: nothing retires and all state clears
    sel = 1'b0;
    exec(4'd0, 3'd7, 3'd0, 16'h4321, 0);
    @(negedge clk);
    op = 4'd2; rx = 3'd7; ry = 3'd7; iv = 1'b1;
    @(negedge clk);
    iv = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    repeat (2) begin
      @(negedge clk);
      chk("abort done", dn16, 0);
      chk("abort ready", rdy16, 0);
    end
    rst = 1'b1;
    clear_model();
    for (int s = 0; s < 2; s++) begin
      sel = s[0];
      chk("abort z", zf, 0);
      chk("abort c", cf, 0);
      check_regs();
    end
    sel = 1'b0;
    repeat (6) begin
      @(negedge clk);
      chk("no late done", dn16, 0);
    end
    for (int k = 0; k < 300; k++) begin
      logic [3:0] o;
      int nr;
      sel = k[0];
      nr = sel ? 4 : 8;
      o = $urandom_range(0, 7) == 0 ? 4'($urandom_range(8, 15)) : 4'($urandom_range(0, 7));
      exec(o, 3'($urandom_range(0, nr - 1)), 3'($urandom_range(0, nr - 1)),
           16'($urandom), bit'($urandom_range(0, 1)));
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
